shift_deserializer: RTL and testbench

Serial-in/parallel-out receiver. It is the far end of the link driven by the shift-register transmitter: it collects N serial bits, presented MSB-first or LSB-first, into a parallel word. It presents the word on a valid/ready output handshake and flags overrun. It sits between the serial line and the datapath register file.

---
 rtl/shift_deserializer.sv | 133 +++++++++++++
 tb/tb_shift_deserializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver with a valid/ready word output and a sticky overrun flag.
// Define SHIFT_DESER_PARITY_EN to append a trailing even-parity bit to every frame.
module shift_deserializer #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         sync,
    input  logic         msb_first,
    input  logic         ser_in,
    input  logic         ser_valid,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun,
    output logic         parity_err
);

`ifdef SHIFT_DESER_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

    localparam int unsigned F  = ParityEn ? N + 1 : N;
    localparam int unsigned CW = $clog2(N + 2);

    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          order_q, order_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          overrun_q, overrun_d;
    logic          parity_err_q, parity_err_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          complete;
    logic          is_parity_bit;
    logic          frame_order;
    logic [N-1:0]  frame_shreg;
    logic [CW-1:0] frame_cnt;
    logic [N-1:0]  shift_val;
    logic [N-1:0]  word;
    logic          word_perr;

    always_comb begin
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        order_d      = order_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;
        parity_err_d = parity_err_q;

        accept = enable & ser_valid;

        // sync discards the partial frame first, so a bit in the same cycle starts a new one
        frame_shreg = sync ? '0 : shreg_q;
        frame_cnt   = sync ? '0 : bit_cnt_q;
        frame_order = (frame_cnt == '0) ? msb_first : order_q;

        shift_val = frame_order ? {frame_shreg[N-2:0], ser_in}
                                : {ser_in, frame_shreg[N-1:1]};

        is_parity_bit = ParityEn && (frame_cnt == CW'(N));
        complete      = accept && (frame_cnt == CW'(F - 1));
        word          = is_parity_bit ? frame_shreg : shift_val;
        word_perr     = is_parity_bit ? ((^frame_shreg) ^ ser_in) : 1'b0;

        if (sync) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
            overrun_d = 1'b0;
        end

        if (accept) begin
            order_d = frame_order;
            if (complete) begin
                shreg_d   = '0;
                bit_cnt_d = '0;
            end else begin
                shreg_d   = shift_val;
                bit_cnt_d = frame_cnt + CW'(1);
            end
        end

        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_data_d   = word;
                out_valid_d  = 1'b1;
                parity_err_d = word_perr;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        busy_d = (bit_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            order_q      <= 1'b1;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            order_q      <= order_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed frames plus randomized traffic
// against a frame-level reference model (bit queue, word assembled arithmetically).
module tb_shift_deserializer;

    localparam int N = 5;
`ifdef SHIFT_DESER_PARITY_EN
    localparam int F = N + 1;
`else
    localparam int F = N;
`endif

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         sync;
    logic         msb_first;
    logic         ser_in;
    logic         ser_valid;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    shift_deserializer #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sync       (sync),
        .msb_first  (msb_first),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "reset";

    // Reference model state
    bit    m_bits[$];
    bit    m_order;
    int    m_data;
    bit    m_valid;
    bit    m_over;
    bit    m_perr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_order = 1'b1;
        m_data  = 0;
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic check_all();
        check_eq("out_data", 32'(out_data), 32'(m_data));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("busy", 32'(busy), 32'(m_bits.size() != 0));
        check_eq("overrun", 32'(overrun), 32'(m_over));
        check_eq("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    // Drive one cycle of inputs, advance the model, then check outputs after the edge.
    task automatic step(input logic en, input logic sy, input logic msb, input logic sin,
                        input logic sv, input logic rdy);
        int word;
        bit pe;
        bit done;
        enable    = en;
        sync      = sy;
        msb_first = msb;
        ser_in    = sin;
        ser_valid = sv;
        out_ready = rdy;
        done = 1'b0;
        word = 0;
        pe   = 1'b0;
        if (sy) begin
            m_bits.delete();
            m_over = 1'b0;
        end
        if (en && sv) begin
            if (m_bits.size() == 0) m_order = msb;
            m_bits.push_back(sin);
            if (m_bits.size() == F) begin
                for (int i = 0; i < N; i++) begin
                    if (m_order) word = (word << 1) | int'(m_bits[i]);
                    else         word = word | (int'(m_bits[i]) << i);
                end
`ifdef SHIFT_DESER_PARITY_EN
                pe = m_bits[N];
                for (int i = 0; i < N; i++) pe = pe ^ m_bits[i];
`endif
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = word;
                m_valid = 1'b1;
                m_perr  = pe;
            end else begin
                m_over = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Trailing parity bit (even parity, optionally corrupted); no-op without parity.
    task automatic par_bit(input logic [N-1:0] data, input logic bad, input logic rdy);
`ifdef SHIFT_DESER_PARITY_EN
        step(1'b1, 1'b0, 1'b1, (^data) ^ bad, 1'b1, rdy);
`endif
    endtask

    // seq is in transmit order, leftmost bit first. Order may change after bit 2.
    task automatic send_frame(input logic [N-1:0] seq, input logic msb, input logic msb_after,
                              input logic rdy, input logic rdy_last);
        logic [N-1:0] data;
        data = '0;
        for (int i = 0; i < N; i++) begin
            if (msb) data[N-1-i] = seq[N-1-i];
            else     data[i]     = seq[N-1-i];
        end
`ifdef SHIFT_DESER_PARITY_EN
        for (int i = 0; i < N; i++)
            step(1'b1, 1'b0, (i < 2) ? msb : msb_after, seq[N-1-i], 1'b1, rdy);
        par_bit(data, 1'b0, rdy_last);
`else
        for (int i = 0; i < N; i++)
            step(1'b1, 1'b0, (i < 2) ? msb : msb_after, seq[N-1-i], 1'b1,
                 (i == N - 1) ? rdy_last : rdy);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        sync      = 1'b0;
        msb_first = 1'b1;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        phase = "msb_first";
        send_frame(5'b10011, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("word", 32'(out_data), 32'h13);
        check_eq("valid", 32'(out_valid), 32'd1);
        check_eq("busy_done", 32'(busy), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("consumed", 32'(out_valid), 32'd0);

        phase = "lsb_first";
        send_frame(5'b11001, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("word", 32'(out_data), 32'h13);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        phase = "lsb_toggle";
        send_frame(5'b11001, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("word", 32'(out_data), 32'h13);

        phase = "gaps_enable";
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("busy_mid", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        par_bit(5'b10011, 1'b0, 1'b1);
        check_eq("word", 32'(out_data), 32'h13);

        phase = "overrun";
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(5'b10011, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(5'b01100, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("kept_word", 32'(out_data), 32'h13);
        check_eq("flag", 32'(overrun), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("cleared", 32'(overrun), 32'd0);
        check_eq("valid_held", 32'(out_valid), 32'd1);
        send_frame(5'b11100, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("b2b_word", 32'(out_data), 32'h1c);
        check_eq("b2b_valid", 32'(out_valid), 32'd1);
        check_eq("b2b_no_ovr", 32'(overrun), 32'd0);

        phase = "resync";
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("no_word", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        par_bit(5'b01101, 1'b0, 1'b0);
        check_eq("word", 32'(out_data), 32'h0d);
        check_eq("valid", 32'(out_valid), 32'd1);

        phase = "parity";
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(5'b10011, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("good", 32'(parity_err), 32'd0);
`ifdef SHIFT_DESER_PARITY_EN
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b1, (i == 0 || i > 2), 1'b1, 1'b1);
        par_bit(5'b10011, 1'b1, 1'b1);
        check_eq("bad", 32'(parity_err), 32'd1);
        check_eq("bad_word", 32'(out_data), 32'h13);
`endif

        phase = "midframe_reset";
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;

        phase = "random";
        for (int c = 0; c < 3000; c++) begin
            logic en;
            en = ($urandom_range(0, 9) != 0);
            step(en, en && ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 7), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
